// File: rtl/baccarat_game_ctrl.sv
// Baccarat hand sequencer: deals four cards, applies natural and
// third-card rules, then lights the winner until reset.
module baccarat_game_ctrl #(
  parameter int NAT_MIN     = 8,
  parameter int P_STAND_MIN = 6
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    P1     = 4'd1,
    D1     = 4'd2,
    P2     = 4'd3,
    D2     = 4'd4,
    DECIDE = 4'd5,
    P3     = 4'd6,
    BANK   = 4'd7,
    D3     = 4'd8,
    DONE   = 4'd9
  } state_t;

  localparam logic [3:0] L_NAT   = 4'(NAT_MIN);
  localparam logic [3:0] L_STAND = 4'(P_STAND_MIN);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_ps;
  logic [3:0] w_ds;
  logic [3:0] w_pval;
  logic       w_bank_draw;
  logic       w_done;

  assign w_ps   = (pscore > 4'd9) ? 4'd9 : pscore;
  assign w_ds   = (dscore > 4'd9) ? 4'd9 : dscore;
  assign w_pval = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  // Banker's drawing table indexed by banker score and player third card
  assign w_bank_draw =
      (w_ds <= 4'd2)
    | ((w_ds == 4'd3) && (w_pval != 4'd8))
    | ((w_ds == 4'd4) && (w_pval >= 4'd2) && (w_pval <= 4'd7))
    | ((w_ds == 4'd5) && (w_pval >= 4'd4) && (w_pval <= 4'd7))
    | ((w_ds == 4'd6) && (w_pval >= 4'd6) && (w_pval <= 4'd7));

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:   w_next = P1;
      P1:     w_next = D1;
      D1:     w_next = P2;
      P2:     w_next = D2;
      D2:     w_next = DECIDE;
      DECIDE: begin
        if ((w_ps >= L_NAT) || (w_ds >= L_NAT)) w_next = DONE;
        else if (w_ps < L_STAND)                w_next = P3;
        else if (w_ds <= 4'd5)                  w_next = D3;
        else                                    w_next = DONE;
      end
      P3:     w_next = BANK;
      BANK:   w_next = w_bank_draw ? D3 : DONE;
      D3:     w_next = DONE;
      DONE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  assign load_pcard1 = (r_state == P1);
  assign load_dcard1 = (r_state == D1);
  assign load_pcard2 = (r_state == P2);
  assign load_dcard2 = (r_state == D2);
  assign load_pcard3 = (r_state == P3);
  assign load_dcard3 = (r_state == D3);

  assign w_done           = (r_state == DONE);
  assign player_win_light = w_done && (w_ps >= w_ds);
  assign dealer_win_light = w_done && (w_ds >= w_ps);
  assign state_out        = r_state;

endmodule

// File: tb/tb_baccarat_game_ctrl.sv
// Bench for baccarat_game_ctrl: table of hands with expected draw path
// and lights, expected states queued per edge and compared after it.
module tb_baccarat_game_ctrl;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore = '0;
  logic [3:0] dscore = '0;
  logic [3:0] pcard3 = '0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
  logic [3:0] state_out;

  baccarat_game_ctrl #(.NAT_MIN(8), .P_STAND_MIN(6)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .state_out        (state_out)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    string      name;
    logic [3:0] ps, ds, pc3;
    bit         pdraw, ddraw;
    logic [3:0] fps, fds;
    bit         pl, dl;
  } hand_t;

  hand_t      hands[$];
  logic [3:0] q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [11:0] got_vec();
    return {state_out, load_pcard1, load_dcard1, load_pcard2,
            load_dcard2, load_pcard3, load_dcard3,
            player_win_light, dealer_win_light};
  endfunction

  // Expected outputs for a state code; lights supplied separately
  function automatic logic [11:0] exp_vec(logic [3:0] s, bit pl, bit dl);
    logic [5:0] stb;
    stb = 6'b0;
    case (s)
      4'd1: stb = 6'b100000;
      4'd2: stb = 6'b010000;
      4'd3: stb = 6'b001000;
      4'd4: stb = 6'b000100;
      4'd6: stb = 6'b000010;
      4'd8: stb = 6'b000001;
      default: stb = 6'b0;
    endcase
    return {s, stb, pl, dl};
  endfunction

  task automatic check(string nm, logic [11:0] got, logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(string nm);
    logic [3:0] e;
    logic [11:0] g;
    logic [11:0] x;
    @(posedge slow_clock);
    #1;
    e = q.pop_front();
    g = got_vec();
    x = exp_vec(e, 1'b0, 1'b0);
    if (e == 4'd9) check(nm, {g[11:2], 2'b00}, x);
    else           check(nm, g, x);
  endtask

  task automatic run_hand(hand_t h);
    reset  = 1'b1;
    pscore = h.ps;
    dscore = h.ds;
    pcard3 = h.pc3;
    @(negedge slow_clock);
    check({h.name, "_rst"}, got_vec(), 12'h000);
    @(negedge slow_clock);
    reset = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      q.push_back(4'(s));
      step({h.name, "_deal"});
    end
    if (h.pdraw) begin
      q.push_back(4'd6);
      step({h.name, "_p3"});
      q.push_back(4'd7);
      step({h.name, "_bank"});
    end
    if (h.ddraw) begin
      q.push_back(4'd8);
      step({h.name, "_d3"});
    end
    q.push_back(4'd9);
    step({h.name, "_done"});
    pscore = h.fps;
    dscore = h.fds;
    #1;
    check({h.name, "_lights"}, got_vec(), exp_vec(4'd9, h.pl, h.dl));
    @(posedge slow_clock);
    #1;
    check({h.name, "_hold"}, got_vec(), exp_vec(4'd9, h.pl, h.dl));
  endtask

  function automatic hand_t mk(string n, int ps, int ds, int pc, bit pd,
                               bit dd, int fp, int fd, bit pl, bit dl);
    hand_t h;
    h.name = n; h.ps = 4'(ps); h.ds = 4'(ds); h.pc3 = 4'(pc);
    h.pdraw = pd; h.ddraw = dd; h.fps = 4'(fp); h.fds = 4'(fd);
    h.pl = pl; h.dl = dl;
    return h;
  endfunction

  initial begin
    hands.push_back(mk("natural",   8, 3, 0,  0, 0, 8, 3, 1, 0));
    hands.push_back(mk("bothdraw",  5, 5, 4,  1, 1, 9, 6, 1, 0));
    hands.push_back(mk("pstand_dd", 7, 4, 0,  0, 1, 7, 7, 1, 1));
    hands.push_back(mk("bank3_p8",  3, 3, 8,  1, 0, 3, 3, 1, 1));
    hands.push_back(mk("bank3_pk",  3, 3, 12, 1, 1, 5, 6, 0, 1));
    hands.push_back(mk("sat15",     15, 9, 0, 0, 0, 15, 9, 1, 1));
    hands.push_back(mk("loss",      2, 6, 0,  1, 0, 2, 6, 0, 1));
    hands.push_back(mk("bothstand", 6, 6, 0,  0, 0, 6, 6, 1, 1));
    hands.push_back(mk("bank7",     1, 7, 6,  1, 0, 4, 7, 0, 1));
    hands.push_back(mk("bank2",     0, 2, 8,  1, 1, 8, 2, 1, 0));
    hands.push_back(mk("bank4_a",   4, 4, 1,  1, 0, 5, 4, 1, 0));
    hands.push_back(mk("bank6_7",   5, 6, 7,  1, 1, 2, 9, 0, 1));
    hands.push_back(mk("dnat9",     2, 9, 0,  0, 0, 2, 9, 0, 1));
    hands.push_back(mk("bank5_3",   4, 5, 3,  1, 0, 4, 5, 0, 1));

    foreach (hands[i]) run_hand(hands[i]);

    reset = 1'b1;
    pscore = 4'd5;
    dscore = 4'd5;
    @(negedge slow_clock);
    reset = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      q.push_back(4'(s));
      step("mid_deal");
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst", got_vec(), 12'h000);
    @(negedge slow_clock);
    reset = 1'b0;
    q.push_back(4'd1);
    step("restart_p1");
    q.push_back(4'd2);
    step("restart_d1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
